data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the data-memory request interface driven by the multicycle core.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Serves the request from an internal 64-bit-wide array after a programmable wait.
//  Returns a response over a second valid/ready handshake.
//  Store byte-lane merging and load lane extraction happen here.
//  Load sign extension stays in the core.
// PARAMETERS
//  DEPTH    256  number of 64-bit words in the array (power of 2, >=2)
//  LATENCY  2    extra wait cycles between accept and response (0..15)
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   synchronous reset, active-low
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; high only in IDLE
//  req_write   in   1   1=store, 0=load
//  req_size    in   2   0=byte 1=half 2=word 3=double
//  req_addr    in   64  byte address
//  req_wdata   in   64  store data, right-justified
//  resp_valid  out  1   response present
//  resp_ready  in   1   core takes response
//  resp_rdata  out  64  load data, right-justified, zero-extended; 0 for stores/errors
//  resp_err    out  1   misaligned or out-of-range request
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; wait counter=0.
//   - Array contents are NOT cleared.
//   - An in-flight request is dropped; an uncommitted store is never written.
//  FSM:
//   - IDLE: req_ready=1. On req_valid, latch write/size/addr/wdata.
//     LATENCY>0 -> WAIT with counter=LATENCY-1. LATENCY==0 -> EXEC.
//   - WAIT: counter decrements each cycle; counter==0 -> EXEC.
//   - EXEC (1 cycle): check request, perform access, load response regs -> RESP.
//   - RESP: resp_valid=1, outputs held stable.
//     On resp_ready -> IDLE; resp_valid drops next cycle.
//  Timing:
//   - Request accepted at edge t; resp_valid first high in cycle t+2+LATENCY.
//   - Earliest next accept is the cycle after the response handshake.
//   - req_ready=0 outside IDLE, so back-to-back requests stall.
//  Check, in EXEC:
//   - Index = addr[63:3]. Out of range if index >= DEPTH.
//   - Misaligned if addr is not a multiple of 1<<size.
//   - Either condition: resp_err=1, resp_rdata=0, no write.
//  Store: lane = addr[2:0]; bytes lane..lane+(1<<size)-1 take req_wdata low bytes.
//   Other bytes of the word are unchanged. resp_rdata=0.
//  Load: resp_rdata = bytes lane..lane+(1<<size)-1 of the word, right-justified.
//   Upper bits are zero.
//  Read/write ordering: a store is visible to the very next load of the same address.
//  Signals are sampled only in the states named above; req_* changes outside IDLE are ignored.
// CONFIGURATION
//  DMEM_COUNT_EN defined:
//   - Adds out ports rd_count[31:0] and wr_count[31:0].
//   - Each increments in EXEC for a non-error load or store, saturating at 32'hFFFFFFFF.
//   - Both reset to 0.
//  DMEM_COUNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Store dw 64'h1122334455667788 @0x10, then load dw @0x10, LATENCY=2
//     -> resp_valid 4 cycles after each accept; rdata=64'h1122334455667788, err=0.
//  2. Store byte 8'hAB @0x13, then load dw @0x10
//     -> rdata=64'h11223344AB667788; load half @0x12 -> rdata=64'h000000000000AB66.
//  3. Load word @0x12 -> resp_err=1, rdata=0.
//     Store dw @ (DEPTH*8) -> err=1 and array unchanged.
//  4. Hold resp_ready=0 for 5 cycles in RESP
//     -> resp_valid/rdata stable, req_ready=0; resp_ready=1 -> req_ready=1 next cycle.
//  5. Assert rst=0 during WAIT of a store @0x20 of 64'hFF
//     -> IDLE next cycle, no response; later load @0x20 returns prior contents.
//  6. With DMEM_COUNT_EN: 3 good loads, 2 good stores, 1 misaligned store
//     -> rd_count=3, wr_count=2; LATENCY=0 build -> resp_valid at t+2.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request/response with programmable wait.
// Optional access counters (rd_count/wr_count) when DMEM_COUNT_EN is defined.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_COUNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 =
    4'((LATENCY > 0) ? LATENCY - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [1:0]  r_size;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_mis;
  logic          w_err;
  logic          w_exec;
  logic          w_wr;
  logic [5:0]    w_sh;
  logic [63:0]   w_word;
  logic [63:0]   w_bmask;
  logic [63:0]   w_lmask;
  logic [63:0]   w_rdata;
  logic [63:0]   w_merge;

  assign w_idx  = r_addr[AW+2:3];
  assign w_oor  = |r_addr[63:AW+3];
  assign w_sh   = {r_addr[2:0], 3'b000};
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_mis   = 1'b0;
    w_bmask = 64'hFF;
    unique case (r_size)
      2'd0: begin
        w_mis   = 1'b0;
        w_bmask = 64'hFF;
      end
      2'd1: begin
        w_mis   = r_addr[0];
        w_bmask = 64'hFFFF;
      end
      2'd2: begin
        w_mis   = |r_addr[1:0];
        w_bmask = 64'hFFFF_FFFF;
      end
      default: begin
        w_mis   = |r_addr[2:0];
        w_bmask = '1;
      end
    endcase
  end

  assign w_err   = w_oor | w_mis;
  assign w_exec  = (r_state == S_EXEC);
  assign w_wr    = w_exec & r_write & ~w_err;
  assign w_rdata = (w_word >> w_sh) & w_bmask;
  assign w_lmask = w_bmask << w_sh;
  assign w_merge = (w_word & ~w_lmask)
                 | ((r_wdata << w_sh) & w_lmask);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= LAT_M1;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_EXEC;
          else r_cnt <= r_cnt - 4'd1;
        end
        S_EXEC: begin
          r_rdata <= (w_err | r_write) ? 64'd0 : w_rdata;
          r_err   <= w_err;
          r_state <= S_RESP;
        end
        default: begin
          if (resp_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Array is never reset; a store only commits in EXEC outside reset.
  always_ff @(posedge clk) begin
    if (rst && w_wr) r_mem[w_idx] <= w_merge;
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

`ifdef DMEM_COUNT_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_count <= 32'd0;
      r_wr_count <= 32'd0;
    end else if (w_exec && !w_err) begin
      if (r_write) begin
        if (r_wr_count != 32'hFFFF_FFFF)
          r_wr_count <= r_wr_count + 32'd1;
      end else begin
        if (r_rd_count != 32'hFFFF_FFFF)
          r_rd_count <= r_rd_count + 32'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule
